// File: rtl/pong_pkg.sv
// pong_pkg: menu item codes, nav FSM state encoding and shared game constants for the pong pause path
package pong_pkg;
   localparam logic [1:0] MENU_CONTINUE = 2'd0;
   localparam logic [1:0] MENU_RESTART  = 2'd1;
   localparam logic [1:0] MENU_QUIT     = 2'd2;
   localparam int MAX_SCORE = 9;
   typedef enum logic [1:0] {NAV_IDLE, NAV_DELAY, NAV_REPEAT, NAV_HELD} nav_state_t;
   function automatic logic [1:0] menu_step(input logic [1:0] cur, input logic up, input int n);
      return up ? ((cur == MENU_CONTINUE) ? 2'(n - 1) : cur - 2'd1)
                : ((int'(cur) == n - 1) ? MENU_CONTINUE : cur + 2'd1);
   endfunction
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-FF synchronizer plus stability counter; level flips after DEBOUNCE_CYCLES steady samples
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   always_ff @(posedge clock) begin
      if (reset) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] == level) cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync[1];
            cnt   <= '0;
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/pause_menu_nav.sv
// pause_menu_nav: debounced joystick cursor over the pause menu (Continue/Restart/Quit)
// PAUSE_MENU_AUTOREPEAT_EN adds hold-to-repeat stepping (DELAY/REPEAT states).
module pause_menu_nav
   import pong_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int NUM_ITEMS       = 3,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 10000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       joy_up_raw,
   input  logic       joy_down_raw,
   input  logic       joy_press_raw,
   input  logic       menu_active,
   output logic [1:0] value,
   output logic       enter,
   output logic       cursor_moved
);
   logic up, down, valid_up, valid_down, prev_up, prev_down, rise, step, move;
   nav_state_t state, state_next;
   generate
      if (NUM_ITEMS < 2 || NUM_ITEMS > 4 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
         $error("pause_menu_nav: parameter out of range");
      end
   endgenerate
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (.clock(clock), .reset(reset), .raw(joy_up_raw), .level(up));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (.clock(clock), .reset(reset), .raw(joy_down_raw), .level(down));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_press (.clock(clock), .reset(reset), .raw(joy_press_raw), .level(enter));
`ifdef PAUSE_MENU_AUTOREPEAT_EN
   localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
   logic [RW-1:0] rcnt, rcnt_next;
   logic dir_up, dir_next, held;
`endif
   always_comb begin
      valid_up   = up & ~down;
      valid_down = down & ~up;
      rise       = (valid_up & ~prev_up) | (valid_down & ~prev_down);
      step       = 1'b0;
      state_next = NAV_IDLE;
`ifdef PAUSE_MENU_AUTOREPEAT_EN
      rcnt_next = rcnt;
      dir_next  = dir_up;
      held      = dir_up ? valid_up : valid_down;
      case (state)
         NAV_IDLE: if (rise) begin
            step       = 1'b1;
            state_next = NAV_DELAY;
            rcnt_next  = RW'(REPEAT_DELAY);
            dir_next   = valid_up;
         end
         NAV_DELAY, NAV_REPEAT: if (held && rcnt == RW'(1)) begin
            step       = 1'b1;
            state_next = NAV_REPEAT;
            rcnt_next  = RW'(REPEAT_RATE);
         end else if (held) begin
            state_next = state;
            rcnt_next  = rcnt - 1'b1;
         end
         default: ;
      endcase
`else
      case (state)
         NAV_IDLE: begin
            step       = rise;
            state_next = rise ? NAV_HELD : NAV_IDLE;
         end
         NAV_HELD: state_next = (valid_up | valid_down) ? NAV_HELD : NAV_IDLE;
         default: ;
      endcase
`endif
      if (!menu_active) begin
         step       = 1'b0;
         state_next = NAV_IDLE;
      end
      // a step requested while the button is down is dropped so value stays stable for the main FSM
      move = step & ~enter;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= NAV_IDLE;
         value        <= MENU_CONTINUE;
         cursor_moved <= 1'b0;
         prev_up      <= 1'b0;
         prev_down    <= 1'b0;
`ifdef PAUSE_MENU_AUTOREPEAT_EN
         rcnt   <= '0;
         dir_up <= 1'b0;
`endif
      end else begin
         state        <= state_next;
         prev_up      <= valid_up;
         prev_down    <= valid_down;
         cursor_moved <= move;
         value        <= !menu_active ? MENU_CONTINUE : move ? menu_step(value, valid_up, NUM_ITEMS) : value;
`ifdef PAUSE_MENU_AUTOREPEAT_EN
         rcnt   <= rcnt_next;
         dir_up <= dir_next;
`endif
      end
   end
endmodule
